minterm_sweep_ctrl: RTL and testbench
=====================================

Name: minterm_sweep_ctrl

Overview:
Sequencer that exhaustively drives the 4-bit select input of the decoder-based function block (4-to-16 decoder feeding the f/g/h OR-planes) through minterms 0..15. It samples f, g and h for each minterm and assembles three 16-bit truth tables. It then compares them against expected minterm masks and reports pass/fail. It sits between the lab top level (start/abort buttons, result LEDs) and the combinational function block.

Parameters:
SETTLE, 0, wait cycles inserted between driving sel_out and sampling f/g/h; legal range 0..15
EXP_F, 16'h4CC8, expected f truth table; bit n = f at minterm n (minterms 3,6,7,10,11,14)
EXP_G, 16'h440C, expected g truth table (minterms 2,3,10,14)
EXP_H, 16'hC08B, expected h truth table (minterms 0,1,3,7,14,15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin sweep; sampled only in IDLE or DONE
abort  input  1  cancel sweep; priority over start
f_in  input  1  f output of function block
g_in  input  1  g output of function block
h_in  input  1  h output of function block
sel_out  output  4  minterm index driven to function block inp
busy  output  1  high in SETTLE, SAMPLE, CHECK
done  output  1  high while in DONE
pass  output  1  valid when done; 1 = all three tables match
fail_mask  output  3  valid when done; {h,g,f} mismatch flags
tt_f  output  16  captured f truth table
tt_g  output  16  captured g truth table
tt_h  output  16  captured h truth table

Behaviour:
- All state is updated on the rising edge of clk. rst is synchronous and active-high, takes priority over everything, and forces state=IDLE. It also clears sel_out, the wait counter, tt_f/g/h, pass, fail_mask, busy and done to 0.
- States: IDLE, SETTLE, SAMPLE, CHECK, DONE. All outputs are registered.
- IDLE or DONE with start=1 and abort=0:
  - clear idx to 0, wait counter, tt_f/g/h, pass and fail_mask;
  - go to SETTLE if SETTLE>0, else go to SAMPLE.
- SETTLE: the wait counter increments each cycle. After SETTLE cycles in this state, go to SAMPLE.
- SAMPLE (one cycle):
  - write tt_f[idx]<=f_in, tt_g[idx]<=g_in, tt_h[idx]<=h_in;
  - if idx==15, go to CHECK;
  - otherwise idx<=idx+1, reset the wait counter, and go to SETTLE (or SAMPLE again if SETTLE==0).
- sel_out always equals idx. The function block is combinational, so f/g/h sampled in SAMPLE correspond to the current sel_out.
- Timing:
  - each minterm takes SETTLE+1 cycles;
  - a full sweep takes 16*(SETTLE+1) cycles from the first SETTLE/SAMPLE cycle;
  - CHECK takes 1 cycle, so done rises 16*(SETTLE+1)+1 cycles after the start-accept edge.
- CHECK (one cycle):
  - fail_mask <= {tt_h!=EXP_H, tt_g!=EXP_G, tt_f!=EXP_F};
  - pass <= (all three equal);
  - go to DONE.
- DONE: done=1. pass, fail_mask and tt_* hold until the next accepted start, abort or rst.
- start while busy is ignored; the sweep is not restarted.
- abort=1 in any state other than IDLE:
  - next state is IDLE;
  - busy=0, done=0, pass=0, fail_mask=0;
  - sel_out and tt_* hold their partial values.
- abort in IDLE is a no-op.
- start and abort asserted in the same cycle: abort wins, so start is not accepted.
- idx never exceeds 15. There is no wrap within a sweep: the transition out of minterm 15 is always SAMPLE->CHECK.

Optional Feature:
MINTERM_SWEEP_FIRSTFAIL_EN
- Defined:
  - adds output ports first_fail_idx[3:0] and first_fail_vld[0:0];
  - at an accepted start both clear to 0;
  - in SAMPLE, if first_fail_vld==0 and any of {h_in,g_in,f_in} differs from the matching EXP bit at idx, capture first_fail_idx<=idx and set first_fail_vld<=1;
  - both hold through DONE and are cleared by rst.
  - first_fail_vld==1 in DONE if and only if pass==0.
- Not defined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
1. Correct function block connected, SETTLE=0, start pulse -> done rises 17 cycles after accept; tt_f=16'h4CC8, tt_g=16'h440C, tt_h=16'hC08B, pass=1, fail_mask=3'b000.
2. Behavioural model with h forced 0 at minterm 7 -> tt_h=16'hC00B, pass=0, fail_mask=3'b100. With MINTERM_SWEEP_FIRSTFAIL_EN: first_fail_idx=7, first_fail_vld=1.
3. SETTLE=3 -> sel_out holds each value for 4 cycles; done rises 65 cycles after accept; results match scenario 1.
4. abort asserted when sel_out=5 -> next cycle state IDLE, busy=0, done=0, pass=0; tt_f bits 0..4 retain sampled values. A new start then completes a clean sweep with pass=1.
5. start and abort in the same cycle from IDLE -> stays IDLE, busy stays 0. start pulsed mid-sweep at sel_out=9 -> ignored; sweep completes at the normal cycle count.
6. rst asserted mid-sweep at sel_out=12 -> next edge: all outputs 0, state IDLE. After rst, start in DONE from a completed run restarts the sweep and clears tt_* to 0 at accept.

Source files
------------

// File: rtl/minterm_sweep_ctrl.sv
// Sweeps sel_out through minterms 0..15 of the decoder function block, captures the f/g/h
// truth tables and checks them against expected masks. Optional feature: MINTERM_SWEEP_FIRSTFAIL_EN.
module minterm_sweep_ctrl #(
    parameter int unsigned SETTLE = 0,
    parameter logic [15:0] EXP_F  = 16'h4CC8,
    parameter logic [15:0] EXP_G  = 16'h440C,
    parameter logic [15:0] EXP_H  = 16'hC08B
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        f_in,
    input  logic        g_in,
    input  logic        h_in,
    output logic [3:0]  sel_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [2:0]  fail_mask,
    output logic [15:0] tt_f,
    output logic [15:0] tt_g,
    output logic [15:0] tt_h
`ifdef MINTERM_SWEEP_FIRSTFAIL_EN
    ,
    output logic [3:0]  first_fail_idx,
    output logic        first_fail_vld
`endif
);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE == 0) ? 0 : SETTLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    // Entry state for every minterm: skip the settle wait entirely when SETTLE is zero.
    localparam state_t ST_FIRST = (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;

    state_t           state;
    logic [CNT_W-1:0] cnt;

`ifdef MINTERM_SWEEP_FIRSTFAIL_EN
    logic [2:0] miss_c;

    always_comb begin
        miss_c = {h_in ^ EXP_H[sel_out], g_in ^ EXP_G[sel_out], f_in ^ EXP_F[sel_out]};
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            sel_out   <= '0;
            cnt       <= '0;
            tt_f      <= '0;
            tt_g      <= '0;
            tt_h      <= '0;
            pass      <= 1'b0;
            fail_mask <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef MINTERM_SWEEP_FIRSTFAIL_EN
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
`endif
        end else if (abort && state != ST_IDLE) begin
            // Abort keeps sel_out and the partial tables for inspection.
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start && !abort) begin
                        sel_out   <= '0;
                        cnt       <= '0;
                        tt_f      <= '0;
                        tt_g      <= '0;
                        tt_h      <= '0;
                        pass      <= 1'b0;
                        fail_mask <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        state     <= ST_FIRST;
`ifdef MINTERM_SWEEP_FIRSTFAIL_EN
                        first_fail_idx <= '0;
                        first_fail_vld <= 1'b0;
`endif
                    end
                end
                ST_SETTLE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == SETTLE_LAST) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    tt_f[sel_out] <= f_in;
                    tt_g[sel_out] <= g_in;
                    tt_h[sel_out] <= h_in;
`ifdef MINTERM_SWEEP_FIRSTFAIL_EN
                    if (!first_fail_vld && miss_c != 3'b000) begin
                        first_fail_idx <= sel_out;
                        first_fail_vld <= 1'b1;
                    end
`endif
                    if (sel_out == 4'hF) begin
                        state <= ST_CHECK;
                    end else begin
                        sel_out <= sel_out + 4'd1;
                        cnt     <= '0;
                        state   <= ST_FIRST;
                    end
                end
                ST_CHECK: begin
                    fail_mask <= {tt_h != EXP_H, tt_g != EXP_G, tt_f != EXP_F};
                    pass      <= (tt_h == EXP_H) && (tt_g == EXP_G) && (tt_f == EXP_F);
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minterm_sweep_ctrl.sv
// Bench for minterm_sweep_ctrl: two instances (SETTLE=0 and SETTLE=3) against a sweep-level model.
`timescale 1ns/1ps
module tb_minterm_sweep_ctrl;
    localparam logic [15:0] EXP_F = 16'h4CC8;
    localparam logic [15:0] EXP_G = 16'h440C;
    localparam logic [15:0] EXP_H = 16'hC08B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] start_a;
    logic [1:0] abort_a;
    logic       fault;

    wire [1:0]        f_a, g_a, h_a;
    wire [1:0]        busy_a, done_a, pass_a;
    wire [1:0][3:0]   sel_a;
    wire [1:0][2:0]   fm_a;
    wire [1:0][15:0]  tf_a, tg_a, th_a;
`ifdef MINTERM_SWEEP_FIRSTFAIL_EN
    wire [1:0][3:0]   ffi_a;
    wire [1:0]        ffv_a;
`endif

    // Function block behaviour; fault drops h at minterm 7.
    wire [15:0] act_f = EXP_F;
    wire [15:0] act_g = EXP_G;
    wire [15:0] act_h = fault ? (EXP_H & ~16'h0080) : EXP_H;

    assign f_a[0] = act_f[sel_a[0]];
    assign g_a[0] = act_g[sel_a[0]];
    assign h_a[0] = act_h[sel_a[0]];
    assign f_a[1] = act_f[sel_a[1]];
    assign g_a[1] = act_g[sel_a[1]];
    assign h_a[1] = act_h[sel_a[1]];

    minterm_sweep_ctrl #(.SETTLE(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_a[0]), .abort(abort_a[0]),
        .f_in(f_a[0]), .g_in(g_a[0]), .h_in(h_a[0]),
        .sel_out(sel_a[0]), .busy(busy_a[0]), .done(done_a[0]), .pass(pass_a[0]),
        .fail_mask(fm_a[0]), .tt_f(tf_a[0]), .tt_g(tg_a[0]), .tt_h(th_a[0])
`ifdef MINTERM_SWEEP_FIRSTFAIL_EN
        , .first_fail_idx(ffi_a[0]), .first_fail_vld(ffv_a[0])
`endif
    );

    minterm_sweep_ctrl #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start_a[1]), .abort(abort_a[1]),
        .f_in(f_a[1]), .g_in(g_a[1]), .h_in(h_a[1]),
        .sel_out(sel_a[1]), .busy(busy_a[1]), .done(done_a[1]), .pass(pass_a[1]),
        .fail_mask(fm_a[1]), .tt_f(tf_a[1]), .tt_g(tg_a[1]), .tt_h(th_a[1])
`ifdef MINTERM_SWEEP_FIRSTFAIL_EN
        , .first_fail_idx(ffi_a[1]), .first_fail_vld(ffv_a[1])
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lowmask(input int n);
        logic [16:0] t;
        t = (17'd1 << n) - 17'd1;
        return t[15:0];
    endfunction

    function automatic int first_diff();
        for (int m = 0; m < 16; m++) begin
            if (act_f[m] != EXP_F[m] || act_g[m] != EXP_G[m] || act_h[m] != EXP_H[m]) return m;
        end
        return 16;
    endfunction

    // Model: mode 0=idle, 1=sweeping, 2=done; kk = edges since start accept.
    int          mode [2];
    int          kk   [2];
    logic [3:0]  e_sel[2];
    logic [15:0] e_tf [2];
    logic [15:0] e_tg [2];
    logic [15:0] e_th [2];
    logic        e_pass[2];
    logic [2:0]  e_fm [2];
    logic [3:0]  e_ffi[2];
    logic        e_ffv[2];
    bit          model_ok = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int p, n, fd;
            p = (i == 0) ? 1 : 4;
            if (rst) begin
                mode[i] <= 0; kk[i] <= 0; e_sel[i] <= '0;
                e_tf[i] <= '0; e_tg[i] <= '0; e_th[i] <= '0;
                e_pass[i] <= 1'b0; e_fm[i] <= '0; e_ffi[i] <= '0; e_ffv[i] <= 1'b0;
            end else if (abort_a[i] && mode[i] != 0) begin
                mode[i] <= 0; e_pass[i] <= 1'b0; e_fm[i] <= '0;
            end else if (mode[i] != 1 && start_a[i] && !abort_a[i]) begin
                mode[i] <= 1; kk[i] <= 0; e_sel[i] <= '0;
                e_tf[i] <= '0; e_tg[i] <= '0; e_th[i] <= '0;
                e_pass[i] <= 1'b0; e_fm[i] <= '0; e_ffi[i] <= '0; e_ffv[i] <= 1'b0;
            end else if (mode[i] == 1) begin
                kk[i] <= kk[i] + 1;
                n = (kk[i] + 1) / p;
                if (n > 16) n = 16;
                if (kk[i] + 1 == 16 * p + 1) begin
                    mode[i] <= 2;
                    e_fm[i] <= {act_h != EXP_H, act_g != EXP_G, act_f != EXP_F};
                    e_pass[i] <= (act_h == EXP_H) && (act_g == EXP_G) && (act_f == EXP_F);
                end else begin
                    e_sel[i] <= 4'((n > 15) ? 15 : n);
                    e_tf[i] <= act_f & lowmask(n);
                    e_tg[i] <= act_g & lowmask(n);
                    e_th[i] <= act_h & lowmask(n);
                    fd = first_diff();
                    if (fd < n) begin
                        e_ffv[i] <= 1'b1;
                        e_ffi[i] <= 4'(fd);
                    end
                end
            end
        end
        model_ok <= model_ok | rst;
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("dut%0d.sel_out", i), 32'(sel_a[i]), 32'(e_sel[i]));
                chk($sformatf("dut%0d.busy", i), 32'(busy_a[i]), 32'(mode[i] == 1));
                chk($sformatf("dut%0d.done", i), 32'(done_a[i]), 32'(mode[i] == 2));
                chk($sformatf("dut%0d.pass", i), 32'(pass_a[i]), 32'(e_pass[i]));
                chk($sformatf("dut%0d.fail_mask", i), 32'(fm_a[i]), 32'(e_fm[i]));
                chk($sformatf("dut%0d.tt_f", i), 32'(tf_a[i]), 32'(e_tf[i]));
                chk($sformatf("dut%0d.tt_g", i), 32'(tg_a[i]), 32'(e_tg[i]));
                chk($sformatf("dut%0d.tt_h", i), 32'(th_a[i]), 32'(e_th[i]));
`ifdef MINTERM_SWEEP_FIRSTFAIL_EN
                chk($sformatf("dut%0d.first_fail_idx", i), 32'(ffi_a[i]), 32'(e_ffi[i]));
                chk($sformatf("dut%0d.first_fail_vld", i), 32'(ffv_a[i]), 32'(e_ffv[i]));
`endif
            end
        end
    end

    task automatic pulse_start(input int i);
        start_a[i] = 1'b1;
        @(negedge clk);
        start_a[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, output int lat);
        lat = 0;
        while (!done_a[i] && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        if (!done_a[i]) chk("done_timeout", 32'(done_a[i]), 32'd1);
    endtask

    task automatic wait_sel(input int i, input logic [3:0] v);
        int c;
        c = 0;
        while (sel_a[i] != v && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("wait_sel", 32'(sel_a[i]), 32'(v));
    endtask

    initial begin
        int lat, n5;
        rst = 1'b1; start_a = '0; abort_a = '0; fault = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", 32'(busy_a[0]), 32'd0);
        chk("reset_done", 32'(done_a[0]), 32'd0);
        chk("reset_sel", 32'(sel_a[0]), 32'd0);
        chk("reset_tt_h", 32'(th_a[0]), 32'd0);

        // Clean sweep, SETTLE=0
        pulse_start(0);
        wait_done(0, lat);
        chk("s1_latency", 32'(lat), 32'd17);
        chk("s1_tt_f", 32'(tf_a[0]), 32'h4CC8);
        chk("s1_tt_g", 32'(tg_a[0]), 32'h440C);
        chk("s1_tt_h", 32'(th_a[0]), 32'hC08B);
        chk("s1_pass", 32'(pass_a[0]), 32'd1);
        chk("s1_fail_mask", 32'(fm_a[0]), 32'd0);

        // h stuck low at minterm 7, restarted from DONE
        fault = 1'b1;
        pulse_start(0);
        wait_done(0, lat);
        chk("s2_tt_h", 32'(th_a[0]), 32'hC00B);
        chk("s2_pass", 32'(pass_a[0]), 32'd0);
        chk("s2_fail_mask", 32'(fm_a[0]), 32'b100);
`ifdef MINTERM_SWEEP_FIRSTFAIL_EN
        chk("s2_first_fail_idx", 32'(ffi_a[0]), 32'd7);
        chk("s2_first_fail_vld", 32'(ffv_a[0]), 32'd1);
`endif
        fault = 1'b0;

        // SETTLE=3 instance
        pulse_start(1);
        lat = 0; n5 = 0;
        while (!done_a[1] && lat < 2000) begin
            if (sel_a[1] == 4'd5) n5++;
            @(negedge clk);
            lat++;
        end
        chk("s3_latency", 32'(lat), 32'd65);
        chk("s3_sel5_hold", 32'(n5), 32'd4);
        chk("s3_tt_f", 32'(tf_a[1]), 32'h4CC8);
        chk("s3_tt_h", 32'(th_a[1]), 32'hC08B);
        chk("s3_pass", 32'(pass_a[1]), 32'd1);

        // Abort at sel_out=5
        pulse_start(0);
        wait_sel(0, 4'd5);
        abort_a[0] = 1'b1;
        @(negedge clk);
        abort_a[0] = 1'b0;
        chk("s4_busy", 32'(busy_a[0]), 32'd0);
        chk("s4_done", 32'(done_a[0]), 32'd0);
        chk("s4_pass", 32'(pass_a[0]), 32'd0);
        chk("s4_sel", 32'(sel_a[0]), 32'd5);
        chk("s4_tt_f", 32'(tf_a[0]), 32'h0008);
        chk("s4_tt_h", 32'(th_a[0]), 32'h000B);
        pulse_start(0);
        wait_done(0, lat);
        chk("s4_rerun_latency", 32'(lat), 32'd17);
        chk("s4_rerun_pass", 32'(pass_a[0]), 32'd1);

        // Leave DONE, then start+abort together in IDLE
        abort_a[0] = 1'b1;
        @(negedge clk);
        abort_a[0] = 1'b0;
        chk("s5_abort_done", 32'(done_a[0]), 32'd0);
        start_a[0] = 1'b1; abort_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0; abort_a[0] = 1'b0;
        chk("s5_same_cycle_busy", 32'(busy_a[0]), 32'd0);
        // start pulsed at sel_out=9 must not restart
        pulse_start(0);
        lat = 0;
        while (!done_a[0] && lat < 2000) begin
            start_a[0] = (sel_a[0] == 4'd9);
            @(negedge clk);
            lat++;
        end
        start_a[0] = 1'b0;
        chk("s5_latency", 32'(lat), 32'd17);
        chk("s5_pass", 32'(pass_a[0]), 32'd1);

        // Reset mid-sweep at sel_out=12
        pulse_start(0);
        wait_sel(0, 4'd12);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("s6_busy", 32'(busy_a[0]), 32'd0);
        chk("s6_sel", 32'(sel_a[0]), 32'd0);
        chk("s6_tt_f", 32'(tf_a[0]), 32'd0);
        chk("s6_done", 32'(done_a[0]), 32'd0);
        chk("s6_dut3_tt_f", 32'(tf_a[1]), 32'd0);
        pulse_start(0);
        wait_done(0, lat);
        chk("s6_done_before_restart", 32'(done_a[0]), 32'd1);
        pulse_start(0);
        chk("s6_restart_tt_f", 32'(tf_a[0]), 32'd0);
        chk("s6_restart_busy", 32'(busy_a[0]), 32'd1);
        wait_done(0, lat);
        chk("s6_restart_latency", 32'(lat), 32'd17);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
